// File: rtl/booth_mac_acc_if.sv
// booth_mac_acc_if
// Handshake bundle between the Booth product stream, the accumulator and the
// result consumer.
//   in_valid / in_ready / in_prod      : product stream into the accumulator
//   out_valid / out_ready / out_acc /
//   out_ovf                            : completed dot-product result
// Modports:
//   master : the side that drives products and consumes results (upstream/downstream)
//   slave  : the accumulator itself
interface booth_mac_acc_if #(
    parameter int PROD_W = 12,
    parameter int ACC_W  = 16
);
    logic                     in_valid;
    logic                     in_ready;
    logic signed [PROD_W-1:0] in_prod;
    logic                     out_valid;
    logic                     out_ready;
    logic signed [ACC_W-1:0]  out_acc;
    logic                     out_ovf;

    modport master (
        output in_valid, in_prod, out_ready,
        input  in_ready, out_valid, out_acc, out_ovf
    );

    modport slave (
        input  in_valid, in_prod, out_ready,
        output in_ready, out_valid, out_acc, out_ovf
    );
endinterface

// File: rtl/booth_mac_acc.sv
// booth_mac_acc
// Accumulates LEN signed products from the 6x6 Booth multiplier into an
// ACC_W-bit signed accumulator and presents the dot-product result, with a
// sticky signed-overflow flag, over a valid/ready handshake.
//
// Ports:
//   clk   : rising-edge clock
//   rst   : synchronous active-high reset, highest priority
//   clr   : synchronous abort of the current accumulation (drops any pending result)
//   bus   : booth_mac_acc_if.slave (product input stream, result output stream)
//   busy  : at least one term accepted and result not yet handed off
//
// Optional feature macro: BOOTH_MAC_ACC_SAT_EN
//   defined   : accumulator saturates on signed overflow
//   undefined : accumulator wraps modulo 2^ACC_W
//   In both builds the sticky overflow flag is set on overflow.
//
// State table:
//   IDLE | no terms accepted
//   ACC  | 1..LEN-1 terms accepted
//   DONE | result presented on out_acc/out_ovf, waiting for out_ready
module booth_mac_acc #(
    parameter int PROD_W = 12,
    parameter int ACC_W  = 16,
    parameter int LEN    = 16,
    parameter int CNT_W  = $clog2(LEN + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clr,
    booth_mac_acc_if.slave  bus,
    output logic            busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                  state;
    logic signed [ACC_W-1:0] acc;
    logic [CNT_W-1:0]        cnt;
    logic                    ovf;

    logic                    accept;
    logic                    last_term;
    logic signed [ACC_W-1:0] prod_ext;
    logic signed [ACC_W-1:0] sum_wrap;
    logic signed [ACC_W-1:0] sum_next;
    logic                    ovf_now;

    // in_ready must follow clr in the same cycle so a product offered
    // alongside clr is never counted.
    assign bus.in_ready = (state != DONE) && !clr;
    assign accept       = bus.in_valid && bus.in_ready;
    assign last_term    = (cnt == CNT_W'(LEN - 1));

    assign prod_ext = ACC_W'(bus.in_prod);
    assign sum_wrap = acc + prod_ext;
    // Overflow: operands share a sign and the wrapped sum does not.
    assign ovf_now  = (acc[ACC_W-1] == prod_ext[ACC_W-1]) &&
                      (sum_wrap[ACC_W-1] != acc[ACC_W-1]);

`ifdef BOOTH_MAC_ACC_SAT_EN
    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    // The direction of an overflow is given by the shared operand sign.
    always_comb begin
        sum_next = sum_wrap;
        if (ovf_now) begin
            sum_next = acc[ACC_W-1] ? ACC_MIN : ACC_MAX;
        end
    end
`else
    always_comb begin
        sum_next = sum_wrap;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            acc           <= '0;
            cnt           <= '0;
            ovf           <= 1'b0;
            bus.out_valid <= 1'b0;
            bus.out_acc   <= '0;
            bus.out_ovf   <= 1'b0;
            busy          <= 1'b0;
        end else if (clr) begin
            // out_acc/out_ovf keep their stale values; out_valid=0 marks them invalid.
            state         <= IDLE;
            acc           <= '0;
            cnt           <= '0;
            ovf           <= 1'b0;
            bus.out_valid <= 1'b0;
            busy          <= 1'b0;
        end else begin
            case (state)
                IDLE, ACC: begin
                    if (accept) begin
                        acc  <= sum_next;
                        cnt  <= cnt + CNT_W'(1);
                        ovf  <= ovf | ovf_now;
                        busy <= 1'b1;
                        if (last_term) begin
                            state         <= DONE;
                            bus.out_valid <= 1'b1;
                            bus.out_acc   <= sum_next;
                            bus.out_ovf   <= ovf | ovf_now;
                        end else begin
                            state <= ACC;
                        end
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state         <= IDLE;
                        acc           <= '0;
                        cnt           <= '0;
                        ovf           <= 1'b0;
                        bus.out_valid <= 1'b0;
                        busy          <= 1'b0;
                    end
                end
                default: begin
                    state         <= IDLE;
                    acc           <= '0;
                    cnt           <= '0;
                    ovf           <= 1'b0;
                    bus.out_valid <= 1'b0;
                    busy          <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/booth_mac_acc.md
Name: booth_mac_acc

Overview:
- Downstream consumer of the 6x6 Booth multiplier's 12-bit signed product stream.
- Accumulates a fixed number of products (LEN terms) into a wide signed accumulator, then presents the dot-product result over a valid/ready handshake.
- Sits between the multiplier and the result register or bus interface; carries the sticky overflow status alongside the result.

Parameters:
- PROD_W, 12, signed product width (two's complement).
- ACC_W, 16, accumulator/result width; must be >= PROD_W.
- LEN, 16, products per result; must be >= 1.
- CNT_W, $clog2(LEN+1), width of the term counter.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
- clr  input  1  synchronous abort/restart of the current accumulation.
- in_valid  input  1  in_prod is valid this cycle.
- in_ready  output  1  block accepts in_prod this cycle.
- in_prod  input  PROD_W  signed product from the multiplier.
- out_valid  output  1  out_acc and out_ovf hold a completed result.
- out_ready  input  1  downstream accepts the result.
- out_acc  output  ACC_W  signed accumulated result.
- out_ovf  output  1  sticky: signed overflow occurred during this result.
- busy  output  1  at least one term has been accepted and the result is not yet handed off.

Behaviour:
- Reset: one clock, one synchronous active-high reset (rst); this is fixed.
- rst=1 at a clock edge sets state IDLE, acc=0, cnt=0, ovf=0, out_valid=0, out_acc=0, out_ovf=0, busy=0, in_ready=1 (in_ready is combinational from state).
- rst has highest priority and wins over any activity, including a reset while in ACC or DONE.
- FSM states:
  - IDLE: no terms accepted.
  - ACC: 1..LEN-1 terms accepted.
  - DONE: result is being presented.
- in_ready = (state != DONE) && !clr.
- Accept = in_valid && in_ready.
- On accept:
  - sum = acc + sign_extend(in_prod, ACC_W).
  - cnt increments.
  - ovf |= signed overflow, defined as: both operands have the same sign and the sum's sign differs.
- State transitions:
  - IDLE -> ACC on an accept when LEN > 1.
  - IDLE/ACC -> DONE on the accept that makes cnt == LEN. LEN=1 goes IDLE -> DONE directly.
  - DONE -> IDLE on out_valid && out_ready; acc, cnt and ovf clear on that same edge.
- Output timing:
  - out_valid = (state == DONE). It rises the cycle after the LEN-th accept (1-cycle latency).
  - out_acc and out_ovf are registered at the transition into DONE.
  - They stay stable while out_valid=1 && out_ready=0.
  - After the handshake they hold their last value; out_valid drops.
- in_valid pulses while in DONE are not accepted. Upstream must hold its data.
- Back-to-back accepts are allowed, one per cycle, with no bubbles.
- busy = (state == ACC) || (state == DONE).
- clr:
  - When rst=0 and clr=1, the edge sets state IDLE, acc=0, cnt=0, ovf=0, out_valid=0.
  - A product presented in the same cycle is dropped, since in_ready=0.
  - clr during DONE discards the pending result; out_acc/out_ovf hold their stale values, flagged as invalid by out_valid=0.
- Arithmetic: two's complement at ACC_W bits. With the optional feature off, the accumulator wraps modulo 2^ACC_W.
- Overflow is sticky per result and is never cleared mid-accumulation except by clr or rst.

Optional Feature:
- Macro: BOOTH_MAC_ACC_SAT_EN.
- Defined:
  - On overflow the accumulator saturates to +(2^(ACC_W-1)-1) for a positive overflow or -(2^(ACC_W-1)) for a negative one.
  - Later terms add to the saturated value.
  - ovf/out_ovf are still set.
- Undefined: accumulation wraps; ovf/out_ovf are still set. No other behaviour differs.

Test Plan:
- Reset: rst=1 for 2 cycles with in_valid=1 -> out_valid=0, out_acc=0, out_ovf=0, busy=0, in_ready=1, and no term is counted.
- LEN=4, back-to-back products 3, -5, 100, 2047 with out_ready=1 -> out_valid=1 exactly one cycle after the 4th accept, out_acc=2145, out_ovf=0; the block is back in IDLE the next cycle.
- Backpressure, LEN=4, products 1, 2, 3, 4 with gaps in in_valid, out_ready=0 for 5 cycles -> out_acc=10 held stable and in_ready=0 throughout DONE; after the handshake the next set 5, 5, 5, 5 gives out_acc=20, proving acc was cleared.
- Overflow, ACC_W=14, LEN=5, five products of 2047 -> macro undefined: out_acc=-6149, out_ovf=1; BOOTH_MAC_ACC_SAT_EN defined: out_acc=8191, out_ovf=1. LEN=4 with four products of -2048 and ACC_W=16 -> out_acc=-8192 (0xE000), out_ovf=0.
- clr, LEN=4: accept 7, 9; pulse clr together with in_valid carrying 50 -> 50 is not accepted, busy=0; then 1, 1, 1, 1 -> out_acc=4, out_ovf=0.
- rst mid-DONE: assert rst while out_valid=1 -> out_valid=0, out_acc=0 next cycle, in_ready=1.
